change_dispenser: RTL and testbench
===================================

# change_dispenser

Downstream stage of `vending_mach`: consumes its `give` strobe and `change` amount and pays the change out as physical 10 Rs and 5 Rs coins through a coin-eject mechanism, one coin at a time, with an acknowledge handshake and jam timeout. It keeps per-denomination tube inventories, greedily uses tens before fives, and reports any amount it could not return as `shortfall`.

## Interface

Parameters:
- `EJECT_TIMEOUT`, default 15: cycles an eject line may stay high without `coin_drop` before the tube is declared jammed.
- `TUBE_MAX`, default 31: saturation limit of each tube counter.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-low.
- `give` in 1: one-cycle strobe from `vending_mach`; latches `change`.
- `change` in 5: rupees to return, valid with `give`.
- `refill` in 1: add `refill_ten`/`refill_five` to the tubes this cycle.
- `refill_ten` in 5: number of 10 Rs coins added.
- `refill_five` in 5: number of 5 Rs coins added.
- `coin_drop` in 1: mechanism acknowledge; one coin has physically left.
- `eject_ten` out 1: request one 10 Rs coin; held until ack or timeout.
- `eject_five` out 1: request one 5 Rs coin; held until ack or timeout.
- `busy` out 1: high from the cycle after an accepted `give` until `done`.
- `done` out 1: one-cycle pulse at end of a payout.
- `shortfall` out 5: rupees not returned; updated with `done`, held until next `done`.
- `ten_count` out 5: 10 Rs coins in tube.
- `five_count` out 5: 5 Rs coins in tube.
- `fault` out 1: a jam timeout occurred during the current/last payout; cleared on next accepted `give`.

## Operation

- Reset (`reset`=0 at an edge): all outputs 0, state IDLE, counters 0, `remaining` 0.
- States: IDLE, SELECT, EJECT, GAP, FINISH.
- IDLE: `give`=1 → latch `remaining`=`change`, clear `fault`, go SELECT. `give` in any other state ignored.
- SELECT (one cycle): `remaining`>=10 and `ten_count`>0 → EJECT(ten); else `remaining`>=5 and `five_count`>0 → EJECT(five); else FINISH.
- EJECT: selected eject line high exactly while in EJECT; never both high. Timer counts cycles in EJECT.
  - `coin_drop`=1 → decrement that tube and `remaining` by 10/5, go GAP.
  - Timer reaches `EJECT_TIMEOUT` without `coin_drop` → `fault`=1, that tube count forced to 0 (jammed), `remaining` unchanged, go SELECT (may fall back to the other denomination).
  - `coin_drop` and timeout on the same edge → `coin_drop` wins, no fault.
- GAP: one cycle, both eject lines low, then SELECT.
- FINISH: `done`=1 for one cycle, `shortfall`=`remaining`, go IDLE.
- Non-multiple-of-5 remainder (e.g. change=7 → 2) is never payable and ends up in `shortfall`.
- `coin_drop` outside EJECT ignored.
- Refill: any state; count_next = min(`TUBE_MAX`, count + refill_x − dec), where dec=1 when that tube is decremented on the same edge. A jam-zeroing on the same edge overrides refill for that tube (result 0).
- Arithmetic: 5-bit unsigned; `remaining` never underflows (guarded by SELECT).

## Timing

- `give` sampled at edge N → SELECT after N; `busy`=1 after N; eject line high after N+1.
- `coin_drop` sampled at edge M → eject low after M; next eject rises after M+2 (GAP, SELECT).
- Minimum latency `give` to `done` with nothing payable: `done` high after edge N+2 (SELECT, FINISH); `busy` low after N+3.
- Timeout: eject line high for exactly `EJECT_TIMEOUT` cycles, then SELECT.
- Reset mid-payout: at the reset edge eject lines, `busy`, `done` drop to 0 and counters to 0; no `done` is emitted for the aborted payout.

## Test plan

- Refill tens=3, fives=3; give change=15, ack each eject after 2 cycles → one `eject_ten`, one `eject_five`, `done` with `shortfall`=0, counts 2/2, `fault`=0.
- Tens=1, fives=0; change=25 → one ten ejected, `shortfall`=15, `ten_count`=0.
- Tens=2, fives=2; change=10, never ack ten → `eject_ten` high 15 cycles, `fault`=1, `ten_count`=0, then two fives acked, `shortfall`=0, `five_count`=0.
- change=7 with fives available → one five, `shortfall`=2; change=0 → `done` 2 cycles after `give`, no eject.
- During payout: second `give` ignored; refill_ten=31 with ten_count=5 on a decrement edge → `ten_count`=31 (saturated); `coin_drop` pulse in IDLE → no count change.
- Assert `reset`=0 while `eject_ten` high → all outputs 0 next edge, no `done`; subsequent `give` works normally after refill.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser
//   Pays out a change amount from vending_mach as 10 Rs / 5 Rs coins, one coin
//   per eject request, greedy tens-first. Each eject is held until the
//   mechanism acknowledges with coin_drop or EJECT_TIMEOUT cycles pass, in
//   which case that tube is treated as jammed (count zeroed, fault raised).
//
// Ports
//   clk, reset       : clock, synchronous active-low reset
//   give, change     : payout request strobe and amount (accepted in IDLE only)
//   refill           : add refill_ten / refill_five coins to the tubes
//   coin_drop        : mechanism ack, one coin has left (honoured in EJECT only)
//   eject_ten/five   : one-coin requests, high exactly while ejecting
//   busy, done       : payout in progress / one-cycle end-of-payout pulse
//   shortfall        : rupees that could not be returned, valid from done
//   ten_count/five_count : tube inventories (saturating at TUBE_MAX)
//   fault            : jam seen in the current/last payout
module change_dispenser #(
  parameter int EJECT_TIMEOUT = 15,
  parameter int TUBE_MAX      = 31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       give,
  input  logic [4:0] change,
  input  logic       refill,
  input  logic [4:0] refill_ten,
  input  logic [4:0] refill_five,
  input  logic       coin_drop,
  output logic       eject_ten,
  output logic       eject_five,
  output logic       busy,
  output logic       done,
  output logic [4:0] shortfall,
  output logic [4:0] ten_count,
  output logic [4:0] five_count,
  output logic       fault
);

  localparam int TW = $clog2(EJECT_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SELECT, EJECT, GAP, FINISH} state_t;

  state_t         state, state_nx;
  logic [4:0]     remaining, rem_nx;
  logic           sel_ten, sel_ten_nx;
  logic [TW-1:0]  timer, timer_nx;
  logic           fault_nx, busy_nx, done_nx;
  logic [4:0]     shortfall_nx, ten_nx, five_nx;
  logic           dec_ten, dec_five, jam_ten, jam_five;
  logic           timeout;

  // count + add - dec, clamped to TUBE_MAX. Computed wide so the clamp sees
  // the true sum; dec never exceeds count because a tube is only selected
  // when non-empty and nothing but a jam can lower it while ejecting.
  function automatic logic [4:0] tube_next(input logic [4:0] cnt,
                                           input logic [4:0] add,
                                           input logic       dec);
    logic [6:0] sum;
    sum = {2'b00, cnt} + {2'b00, add} - {6'd0, dec};
    if (sum > 7'(TUBE_MAX)) return 5'(TUBE_MAX);
    return sum[4:0];
  endfunction

  // Timer holds the number of completed EJECT cycles, so the line stays high
  // for exactly EJECT_TIMEOUT cycles before the jam is declared.
  assign timeout    = (timer == TW'(EJECT_TIMEOUT - 1));
  assign eject_ten  = (state == EJECT) &&  sel_ten;
  assign eject_five = (state == EJECT) && !sel_ten;

  always_comb begin
    state_nx     = state;
    rem_nx       = remaining;
    sel_ten_nx   = sel_ten;
    timer_nx     = timer;
    fault_nx     = fault;
    busy_nx      = busy & ~done;   // busy covers the done cycle, drops after
    done_nx      = 1'b0;
    shortfall_nx = shortfall;
    dec_ten      = 1'b0;
    dec_five     = 1'b0;
    jam_ten      = 1'b0;
    jam_five     = 1'b0;

    case (state)
      IDLE: begin
        if (give) begin
          rem_nx   = change;
          fault_nx = 1'b0;
          busy_nx  = 1'b1;
          state_nx = SELECT;
        end
      end
      SELECT: begin
        timer_nx = '0;
        if (remaining >= 5'd10 && ten_count != 5'd0) begin
          sel_ten_nx = 1'b1;
          state_nx   = EJECT;
        end else if (remaining >= 5'd5 && five_count != 5'd0) begin
          sel_ten_nx = 1'b0;
          state_nx   = EJECT;
        end else begin
          state_nx = FINISH;
        end
      end
      EJECT: begin
        if (coin_drop) begin
          // ack beats a simultaneous timeout
          dec_ten  = sel_ten;
          dec_five = !sel_ten;
          rem_nx   = remaining - (sel_ten ? 5'd10 : 5'd5);
          state_nx = GAP;
        end else if (timeout) begin
          fault_nx = 1'b1;
          jam_ten  = sel_ten;
          jam_five = !sel_ten;
          state_nx = SELECT;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      GAP:    state_nx = SELECT;
      FINISH: begin
        done_nx      = 1'b1;
        shortfall_nx = remaining;
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // a jammed tube reads empty regardless of a same-cycle refill
    ten_nx  = jam_ten  ? 5'd0 : tube_next(ten_count,  refill ? refill_ten  : 5'd0, dec_ten);
    five_nx = jam_five ? 5'd0 : tube_next(five_count, refill ? refill_five : 5'd0, dec_five);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      remaining  <= '0;
      sel_ten    <= 1'b0;
      timer      <= '0;
      fault      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      shortfall  <= '0;
      ten_count  <= '0;
      five_count <= '0;
    end else begin
      state      <= state_nx;
      remaining  <= rem_nx;
      sel_ten    <= sel_ten_nx;
      timer      <= timer_nx;
      fault      <= fault_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      shortfall  <= shortfall_nx;
      ten_count  <= ten_nx;
      five_count <= five_nx;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       give = 1'b0;
  logic [4:0] change = '0;
  logic       refill_m = 1'b0, refill_d = 1'b0;
  logic [4:0] rt_m = '0, rf_m = '0;
  logic       refill;
  logic [4:0] refill_ten, refill_five;
  logic       coin_drop = 1'b0;
  logic       eject_ten, eject_five, busy, done, fault;
  logic [4:0] shortfall, ten_count, five_count;

  assign refill      = refill_m | refill_d;
  assign refill_ten  = refill_d ? 5'd31 : rt_m;
  assign refill_five = refill_d ? 5'd0  : rf_m;

  change_dispenser #(.EJECT_TIMEOUT(15), .TUBE_MAX(31)) dut (
    .clk(clk), .reset(reset), .give(give), .change(change),
    .refill(refill), .refill_ten(refill_ten), .refill_five(refill_five),
    .coin_drop(coin_drop), .eject_ten(eject_ten), .eject_five(eject_five),
    .busy(busy), .done(done), .shortfall(shortfall), .ten_count(ten_count),
    .five_count(five_count), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {int sf; int flt; int ten; int five; int n10; int n5;} exp_t;
  exp_t sbq[$];

  int checks = 0, passed = 0;
  int mt = 0, mf = 0;          // reference tube contents

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference payout: greedy tens then fives in closed form. A jam on a
  // denomination costs one eject attempt and empties that tube.
  function automatic exp_t model(input int c, input bit jt, input bit jf);
    exp_t e;
    int rem, k;
    rem = c; e.n10 = 0; e.n5 = 0; e.flt = 0;
    if (rem >= 10 && mt > 0) begin
      if (jt) begin e.flt = 1; e.n10 = 1; mt = 0; end
      else begin k = (rem / 10 < mt) ? rem / 10 : mt; e.n10 = k; mt -= k; rem -= 10 * k; end
    end
    if (rem >= 5 && mf > 0) begin
      if (jf) begin e.flt = 1; e.n5 = 1; mf = 0; end
      else begin k = (rem / 5 < mf) ? rem / 5 : mf; e.n5 = k; mf -= k; rem -= 5 * k; end
    end
    e.sf = rem; e.ten = mt; e.five = mf;
    return e;
  endfunction

  // ---------------- coin mechanism driver ----------------
  bit jam_t = 0, jam_f = 0, stray = 0, sat = 0;
  int ack_dly = 2, hi = 0, ten_len = 0;
  bit prev_ten = 0;
  initial forever begin
    @(negedge clk);
    if (prev_ten && !eject_ten) ten_len = hi;
    if (eject_ten || eject_five) begin
      hi++;
      coin_drop = stray || (!(eject_ten ? jam_t : jam_f) && hi >= ack_dly);
    end else begin
      hi = 0;
      coin_drop = stray;
    end
    refill_d = sat && coin_drop && eject_ten;
    prev_ten = eject_ten;
  end

  // ---------------- monitor / scoreboard ----------------
  int done_cnt = 0, n10 = 0, n5 = 0;
  bit pt = 0, pf = 0;
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset) begin
      sbq.delete(); n10 = 0; n5 = 0;
    end
    if (eject_ten && !pt) n10++;
    if (eject_five && !pf) n5++;
    pt = eject_ten; pf = eject_five;
    if (eject_ten || eject_five) chk("one_eject", int'(eject_ten & eject_five), 0);
    if (done) begin
      done_cnt++;
      if (sbq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got done with shortfall %0d, expected no done", shortfall);
      end else begin
        e = sbq.pop_front();
        chk("shortfall", int'(shortfall), e.sf);
        chk("fault", int'(fault), e.flt);
        chk("ten_count", int'(ten_count), e.ten);
        chk("five_count", int'(five_count), e.five);
        chk("ten_ejects", n10, e.n10);
        chk("five_ejects", n5, e.n5);
      end
      n10 = 0; n5 = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_refill(input int a, input int b);
    @(posedge clk); #1 refill_m = 1; rt_m = 5'(a); rf_m = 5'(b);
    @(posedge clk); #1 refill_m = 0; rt_m = '0; rf_m = '0;
    mt = (mt + a > 31) ? 31 : mt + a;
    mf = (mf + b > 31) ? 31 : mf + b;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1 reset = 0;
    @(posedge clk); #1 reset = 1;
    mt = 0; mf = 0;
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 400) begin @(negedge clk); n++; end
    if (done_cnt == d0) chk("done_timeout", 0, 1);
    repeat (2) @(posedge clk);
  endtask

  task automatic pay(input int c, input bit jt, input bit jf, input bit mid_give);
    int d0;
    sbq.push_back(model(c, jt, jf));
    jam_t = jt; jam_f = jf;
    d0 = done_cnt;
    @(posedge clk); #1 give = 1; change = 5'(c);
    @(posedge clk); #1 give = 0;
    if (mid_give) begin
      repeat (3) @(posedge clk);
      #1 give = 1; change = 5'd25;
      @(posedge clk); #1 give = 0;
    end
    wait_done(d0);
    jam_t = 0; jam_f = 0;
  endtask

  initial begin
    int d0, n;
    exp_t e;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", int'({eject_ten, eject_five, busy, done, fault, shortfall, ten_count, five_count}), 0);
    @(posedge clk); #1 reset = 1;

    // 15 Rs from 3/3 with timing of first eject
    do_refill(3, 3);
    sbq.push_back(model(15, 0, 0));
    d0 = done_cnt;
    @(posedge clk); #1 give = 1; change = 5'd15;
    @(posedge clk); #1 give = 0;
    @(negedge clk);
    chk("busy_after_give", int'(busy), 1);
    chk("no_eject_in_select", int'(eject_ten), 0);
    @(negedge clk);
    chk("eject_ten_rises", int'(eject_ten), 1);
    wait_done(d0);

    // one ten only, 15 short
    reset_dut();
    do_refill(1, 0);
    pay(25, 0, 0, 0);

    // ten jams, fives cover it; second give mid-payout is ignored
    reset_dut();
    do_refill(2, 2);
    pay(10, 1, 0, 1);
    chk("jam_high_cycles", ten_len, 15);

    // non-multiple of 5, then zero change latency
    do_refill(0, 2);
    pay(7, 0, 0, 0);
    sbq.push_back(model(0, 0, 0));
    d0 = done_cnt;
    @(posedge clk); #1 give = 1; change = 5'd0;
    @(posedge clk); #1 give = 0;
    @(negedge clk); chk("zero_busy_n", int'(busy), 1); chk("zero_done_n", int'(done), 0);
    @(negedge clk); chk("zero_done_n1", int'(done), 0);
    @(negedge clk); chk("zero_done_n2", int'(done), 1);
    @(negedge clk); chk("zero_busy_n3", int'(busy), 0);
    wait_done(d0);

    // saturating refill on the decrement edge
    reset_dut();
    do_refill(5, 0);
    e.sf = 0; e.flt = 0; e.n10 = 1; e.n5 = 0; e.five = 0;
    e.ten = (mt + 31 - 1 > 31) ? 31 : mt + 31 - 1;
    mt = e.ten;
    sbq.push_back(e);
    sat = 1;
    d0 = done_cnt;
    @(posedge clk); #1 give = 1; change = 5'd10;
    @(posedge clk); #1 give = 0;
    wait_done(d0);
    sat = 0;

    // coin_drop while idle changes nothing
    @(posedge clk); #1 stray = 1;
    @(posedge clk); #1 stray = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("stray_ten", int'(ten_count), mt);
    chk("stray_five", int'(five_count), mf);

    // reset while eject_ten is high
    jam_t = 1;
    @(posedge clk); #1 give = 1; change = 5'd10;
    @(posedge clk); #1 give = 0;
    n = 0;
    while (!eject_ten && n < 20) begin @(negedge clk); n++; end
    chk("abort_eject_seen", int'(eject_ten), 1);
    @(posedge clk); #1 reset = 0;
    @(posedge clk); #1 reset = 1;
    mt = 0; mf = 0; jam_t = 0;
    @(negedge clk);
    chk("abort_outputs", int'({eject_ten, eject_five, busy, done, fault, shortfall, ten_count, five_count}), 0);
    d0 = done_cnt;
    repeat (6) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    do_refill(2, 2);
    pay(15, 0, 0, 0);

    // randomized payouts
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 1) == 1) do_refill($urandom_range(0, 6), $urandom_range(0, 6));
      ack_dly = $urandom_range(1, 4);
      pay($urandom_range(0, 31), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
